dram_timing_ctrl: RTL
=====================

Name: dram_timing_ctrl

Overview:
- DRAM command-timing controller that drives the timing_ctrl side of timing_signals_if.
- Accepts one DRAM command at a time from the command FSM.
- Counts the JEDEC-style delay for that command and pulses the matching *_done signal.
- Opens the rd_en/wr_en burst windows for data transfer and generates periodic refresh requests (rf_req) from a free-running tREFI counter.

Parameters:
- T_RCD, 4: ACT to row-ready cycles
- T_CL, 3: RD to first read-data cycle
- T_CWL, 2: WR to first write-data cycle
- T_WR, 3: write recovery after last write beat
- T_RP, 4: PRE duration
- T_RFC, 12: REF duration
- T_REFI, 100: refresh interval in cycles
- BURST_LEN, 4: data beats per RD/WR
- CNT_W, 8: timing counter width; must hold max(T_CWL+BURST_LEN+T_WR, T_CL+BURST_LEN, T_RFC, T_RCD, T_RP)

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- cmd_valid  in  1  command strobe from cmd FSM
- cmd  in  3  dram_pkg::cmd_t (NOP, ACT, RD, WR, PRE, REF)
- ready  out  1  controller idle, command will be accepted
- cmd_err  out  1  one-cycle pulse: command strobed while not ready
- tif  modport  timing_signals_if.timing_ctrl; drives tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done, rf_req, wr_en, rd_en, clear (all 1 bit)
- rf_overdue  out  1  one-cycle pulse: refresh interval expired while rf_req already pending

Behaviour:
- Reset (async, nRST=0): state IDLE, all counters 0, every output 0 except ready=1.
- States: IDLE, ACT_W, RD_W, WR_W, PRE_W, REF_W. ready = (state==IDLE).
- Accept: cmd_valid && ready && cmd!=NOP in cycle k. Enter the matching *_W state at edge k+1. cmd==NOP is ignored.
- Done timing, one-cycle pulse, state returns to IDLE at the following edge:
  - ACT: tACT_done in cycle k+T_RCD
  - PRE: tPRE_done in cycle k+T_RP
  - REF: tREF_done in cycle k+T_RFC
  - RD: rd_en high cycles k+T_CL .. k+T_CL+BURST_LEN-1; tRD_done in cycle k+T_CL+BURST_LEN
  - WR: wr_en high cycles k+T_CWL .. k+T_CWL+BURST_LEN-1; tWR_done in cycle k+T_CWL+BURST_LEN+T_WR
- clear = OR of all *_done, same cycle. Exactly one *_done is high per cycle at most.
- Busy strobe: cmd_valid while !ready gives cmd_err=1 in cycle k+1. The command is dropped; state and counters are unaffected.
- Refresh counter:
  - Free-running from reset, counts 0..T_REFI-1 and wraps.
  - On wrap, rf_req is set, registered: high from cycle T_REFI after reset.
  - rf_req is cleared at the edge after a REF is accepted.
  - Wrap with rf_req already 1: rf_overdue pulses, rf_req stays 1.
  - Wrap in the same cycle as REF accept: the new request wins and rf_req stays 1.
- rf_req is advisory only. The block never blocks ACT/RD/WR while rf_req=1; the cmd FSM prioritises.
- Counter arithmetic is unsigned CNT_W. The down-counter loads (delay-1) on accept and is never negative.
- Reset mid-operation aborts immediately: rd_en/wr_en drop in the same cycle (asynchronously), and the refresh counter restarts from 0.

Decomposition:
- dram_pkg:
  - cmd_t enum
  - timing_state_t enum
  - default timing constants (T_RCD_D etc.), so parameters default from the package
- Sub-module refresh_timer (T_REFI counter, rf_req/rf_overdue logic; inputs: ref_accept). The FSM and burst-window logic stay in dram_timing_ctrl.

Test Plan:
- Reset, ACT accepted cycle 0 -> tACT_done=clear=1 cycle 4 only; ready=0 cycles 1-4, 1 at cycle 5; no rd_en/wr_en.
- RD cycle 0 -> rd_en=1 cycles 3-6, tRD_done=clear=1 cycle 7; WR cycle 0 -> wr_en=1 cycles 2-5, tWR_done cycle 9.
- Run from reset, no REF -> rf_req rises cycle 100. REF at cycle 105 -> rf_req=0 from cycle 106, tREF_done cycle 117, rf_req rises again cycle 200.
- No REF for 200 cycles -> rf_overdue single pulse at cycle 200, rf_req held 1. REF accepted exactly at wrap cycle -> rf_req remains 1.
- PRE at cycle 0, cmd_valid RD at cycle 2 -> cmd_err=1 cycle 3, no rd_en ever, tPRE_done cycle 4 only.
- RD at cycle 0, nRST low cycle 4 -> rd_en=0 immediately, ready=1, no tRD_done. After release, ACT timing matches scenario 1.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared command/state encodings and default DRAM timing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dram_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACT_W = 3'd1,
    ST_RD_W  = 3'd2,
    ST_WR_W  = 3'd3,
    ST_PRE_W = 3'd4,
    ST_REF_W = 3'd5
  } timing_state_t;

  localparam int T_RCD_D     = 4;
  localparam int T_CL_D      = 3;
  localparam int T_CWL_D     = 2;
  localparam int T_WR_D      = 3;
  localparam int T_RP_D      = 4;
  localparam int T_RFC_D     = 12;
  localparam int T_REFI_D    = 100;
  localparam int BURST_LEN_D = 4;
  localparam int CNT_W_D     = 8;

endpackage

// File: rtl/timing_signals_if.sv
// Timing handshake between the DRAM timing controller and the command FSM.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are one-way strobes/levels from the timing controller.
interface timing_signals_if;

  logic tACT_done;
  logic tWR_done;
  logic tRD_done;
  logic tPRE_done;
  logic tREF_done;
  logic rf_req;
  logic wr_en;
  logic rd_en;
  logic clear;

  modport timing_ctrl (
    output tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done,
    output rf_req, wr_en, rd_en, clear
  );

  modport cmd_fsm (
    input tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done,
    input rf_req, wr_en, rd_en, clear
  );

endinterface

// File: rtl/refresh_timer.sv
// Free-running tREFI counter raising a sticky refresh request and an overdue pulse.
// Latency: rf_req rises one cycle after the counter wraps; clears one cycle after a REF accept.
// Backpressure: none; the request is advisory and never stalls other commands.
module refresh_timer #(
  parameter int T_REFI = dram_pkg::T_REFI_D
) (
  input  logic CLK,
  input  logic nRST,
  input  logic ref_accept_i,
  output logic rf_req_o,
  output logic rf_overdue_o
);

  localparam int RW = (T_REFI > 1) ? $clog2(T_REFI) : 1;

  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          rf_req_q, rf_req_d;
  logic          overdue_q, overdue_d;
  logic          wrap;

  // Next-state: wrap the interval counter; a fresh wrap outranks a same-cycle REF accept.
  always_comb begin
    wrap      = (ref_cnt_q == RW'(T_REFI - 1));
    ref_cnt_d = wrap ? '0 : ref_cnt_q + RW'(1);
    rf_req_d  = rf_req_q;
    overdue_d = 1'b0;
    if (wrap) begin
      rf_req_d  = 1'b1;
      // A REF accepted on the wrap cycle services the old request, so it is not overdue.
      overdue_d = rf_req_q && !ref_accept_i;
    end else if (ref_accept_i) begin
      rf_req_d  = 1'b0;
    end
  end

  // State registers; reset restarts the interval from zero.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ref_cnt_q <= '0;
      rf_req_q  <= 1'b0;
      overdue_q <= 1'b0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      rf_req_q  <= rf_req_d;
      overdue_q <= overdue_d;
    end
  end

  assign rf_req_o     = rf_req_q;
  assign rf_overdue_o = overdue_q;

endmodule

// File: rtl/dram_timing_ctrl.sv
// DRAM command timing: counts per-command delays, opens rd/wr burst windows, pulses *_done.
// Latency: command accepted in cycle k completes in cycle k+delay; idle again at k+delay+1.
// Backpressure: ready low while a command is timing; strobes while busy are dropped with cmd_err.
module dram_timing_ctrl
  import dram_pkg::*;
#(
  parameter int T_RCD     = T_RCD_D,
  parameter int T_CL      = T_CL_D,
  parameter int T_CWL     = T_CWL_D,
  parameter int T_WR      = T_WR_D,
  parameter int T_RP      = T_RP_D,
  parameter int T_RFC     = T_RFC_D,
  parameter int T_REFI    = T_REFI_D,
  parameter int BURST_LEN = BURST_LEN_D,
  parameter int CNT_W     = CNT_W_D
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    cmd_valid,
  input  cmd_t                    cmd,
  output logic                    ready,
  output logic                    cmd_err,
  output logic                    rf_overdue,
  timing_signals_if.timing_ctrl   tif
);

  // Counter load values: the down-counter hits zero on the completion cycle.
  localparam logic [CNT_W-1:0] LD_ACT = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] LD_RD  = CNT_W'(T_CL + BURST_LEN - 1);
  localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(T_CWL + BURST_LEN + T_WR - 1);
  localparam logic [CNT_W-1:0] LD_PRE = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] LD_REF = CNT_W'(T_RFC - 1);
  // Burst windows expressed as remaining-count ranges.
  localparam logic [CNT_W-1:0] RD_LO  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RD_HI  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] WR_LO  = CNT_W'(T_WR + 1);
  localparam logic [CNT_W-1:0] WR_HI  = CNT_W'(T_WR + BURST_LEN);

  timing_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             act_done_q, act_done_d;
  logic             rd_done_q, rd_done_d;
  logic             wr_done_q, wr_done_d;
  logic             pre_done_q, pre_done_d;
  logic             ref_done_q, ref_done_d;
  logic             rd_en_q, rd_en_d;
  logic             wr_en_q, wr_en_d;
  logic             clear_q, clear_d;
  logic             accept;
  logic             ref_accept;
  logic             rf_req_w;
  logic             rf_overdue_w;

  // Next-state and next-output decode: outputs are computed from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = cmd_valid && (state_q == ST_IDLE) && (cmd != CMD_NOP);
    if (state_q == ST_IDLE) begin
      if (accept) begin
        case (cmd)
          CMD_ACT: begin state_d = ST_ACT_W; cnt_d = LD_ACT; end
          CMD_RD:  begin state_d = ST_RD_W;  cnt_d = LD_RD;  end
          CMD_WR:  begin state_d = ST_WR_W;  cnt_d = LD_WR;  end
          CMD_PRE: begin state_d = ST_PRE_W; cnt_d = LD_PRE; end
          CMD_REF: begin state_d = ST_REF_W; cnt_d = LD_REF; end
          default: ;
        endcase
      end
    end else if (cnt_q == '0) begin
      state_d = ST_IDLE;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    ref_accept = accept && (cmd == CMD_REF);
    ready_d    = (state_d == ST_IDLE);
    err_d      = cmd_valid && (state_q != ST_IDLE);
    act_done_d = (state_d == ST_ACT_W) && (cnt_d == '0);
    rd_done_d  = (state_d == ST_RD_W)  && (cnt_d == '0);
    wr_done_d  = (state_d == ST_WR_W)  && (cnt_d == '0);
    pre_done_d = (state_d == ST_PRE_W) && (cnt_d == '0);
    ref_done_d = (state_d == ST_REF_W) && (cnt_d == '0);
    rd_en_d    = (state_d == ST_RD_W) && (cnt_d >= RD_LO) && (cnt_d <= RD_HI);
    wr_en_d    = (state_d == ST_WR_W) && (cnt_d >= WR_LO) && (cnt_d <= WR_HI);
    clear_d    = act_done_d | rd_done_d | wr_done_d | pre_done_d | ref_done_d;
  end

  // FSM state, counter and registered outputs; reset drops the data windows immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      act_done_q <= 1'b0;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      pre_done_q <= 1'b0;
      ref_done_q <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      act_done_q <= act_done_d;
      rd_done_q  <= rd_done_d;
      wr_done_q  <= wr_done_d;
      pre_done_q <= pre_done_d;
      ref_done_q <= ref_done_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      clear_q    <= clear_d;
    end
  end

  refresh_timer #(
    .T_REFI (T_REFI)
  ) u_refresh_timer (
    .CLK          (CLK),
    .nRST         (nRST),
    .ref_accept_i (ref_accept),
    .rf_req_o     (rf_req_w),
    .rf_overdue_o (rf_overdue_w)
  );

  assign ready         = ready_q;
  assign cmd_err       = err_q;
  assign rf_overdue    = rf_overdue_w;
  assign tif.tACT_done = act_done_q;
  assign tif.tRD_done  = rd_done_q;
  assign tif.tWR_done  = wr_done_q;
  assign tif.tPRE_done = pre_done_q;
  assign tif.tREF_done = ref_done_q;
  assign tif.rd_en     = rd_en_q;
  assign tif.wr_en     = wr_en_q;
  assign tif.clear     = clear_q;
  assign tif.rf_req    = rf_req_w;

endmodule
